// File: rtl/mult_sequencer.sv
// Iterative shift-add HI/LO multiplier with decode stall generation.
// Latency: busy for WIDTH+1 cycles after accept; HI/LO written on the edge ending the SIGN cycle.
// Backpressure: stall is raised while busy if decode holds MFHI/MFLO or another MULT/MULTU.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             read_hi,
  input  logic             read_lo,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Signed operands are reduced to magnitudes; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [PW-1:0]    product;

  assign rs_mag  = rs_data[WIDTH-1] ? (~rs_data + WIDTH'(1)) : rs_data;
  assign rt_mag  = rt_data[WIDTH-1] ? (~rt_data + WIDTH'(1)) : rt_data;
  assign product = neg_q ? (~acc_q + PW'(1)) : acc_q;

  // Next-state, datapath and status outputs; every state update is computed here.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy     = (state_q != IDLE);
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_mult) begin
          if (mult_sign) begin
            mcand_d  = rs_mag;
            mplier_d = rt_mag;
            neg_d    = rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
          end else begin
            mcand_d  = rs_data;
            mplier_d = rt_data;
            neg_d    = 1'b0;
          end
          acc_d   = '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // One partial product per cycle, always the full WIDTH steps.
        if (mplier_q[count_q]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << count_q);
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        done    = 1'b1;
        hi_d    = product[PW-1:WIDTH];
        lo_d    = product[WIDTH-1:0];
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // In IDLE a MULT proceeds down the pipe and HI/LO are already current.
    stall = busy & (read_hi | read_lo | start_mult);
  end

  // State register with synchronous reset that abandons any in-flight multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
